// File: rtl/aurora_chk_pkg.sv
// Shared types and LFSR helper for the Aurora frame generator/checker pair.
// Pure definitions: no latency, no flow control.
package aurora_chk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DISCARD  = 2'd2
    } chk_state_e;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hABCD;
    localparam logic [7:0]  ERR_CNT_MAX       = 8'hFF;

    // Taps 16,14,13,11 in XNOR form, so the all-zero word is a legal state.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return {cur[14:0], ~(cur[15] ^ cur[13] ^ cur[12] ^ cur[10])};
    endfunction

endpackage

// File: rtl/aurora_rx_frame_checker_if.sv
// Receive-side AXI4-Stream user interface (no TREADY; the sink always accepts).
// Wires only: no latency, no backpressure.
interface aurora_rx_frame_checker_if #(
    parameter int DATA_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] RX_TDATA;
    logic [STRB_WIDTH-1:0] RX_TKEEP;
    logic                  RX_TLAST;
    logic                  RX_TVALID;

    modport master (output RX_TDATA, RX_TKEEP, RX_TLAST, RX_TVALID);
    modport slave  (input  RX_TDATA, RX_TKEEP, RX_TLAST, RX_TVALID);
endinterface

// File: rtl/aurora_rx_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Value updates one cycle after inc/clr; no flow control.
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != MAX)) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/aurora_rx_frame_checker.sv
// Checks received words against the free-running LFSR and checks frame structure.
// Pulses/counters update one cycle after each beat; every valid beat is accepted.
module aurora_rx_frame_checker
    import aurora_chk_pkg::*;
#(
    parameter int          DATA_WIDTH      = 16,
    parameter int          STRB_WIDTH      = 2,
    parameter int          MAX_FRAME_BEATS = 256,
    parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEFAULT
) (
    input  logic                      USER_CLK,
    input  logic                      RESET_N,
    input  logic                      CHANNEL_UP,
    aurora_rx_frame_checker_if.slave  rx,
    output logic                      DATA_ERR,
    output logic                      FRAME_ERR,
    output logic [7:0]                ERR_COUNT,
    output logic [7:0]                FRAME_ERR_COUNT,
    output logic [15:0]               FRAME_COUNT
);

    localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BEATS);

    logic [DATA_WIDTH-1:0] rx_dat;
    logic [STRB_WIDTH-1:0] rx_keep;
    logic                  rx_last;
    logic                  rx_vld;

    chk_state_e  state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic        frame_bad_q, frame_bad_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        data_err_q, data_err_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic byte_mis;
    logic keep_viol;
    logic overlen;
    logic frame_viol;
    logic close_ok;

    assign rx_dat  = rx.RX_TDATA;
    assign rx_keep = rx.RX_TKEEP;
    assign rx_last = rx.RX_TLAST;
    assign rx_vld  = rx.RX_TVALID & CHANNEL_UP;

    // Byte 0 travels in the upper half of the word.
    assign byte_mis   = (rx_keep[1] && (rx_dat[15:8] != lfsr_q[15:8])) ||
                        (rx_keep[0] && (rx_dat[7:0]  != lfsr_q[7:0]));
    assign keep_viol  = rx_last ? (rx_keep == 2'b00) : (rx_keep != 2'b11);
    assign overlen    = (state_q == IN_FRAME) && (beat_cnt_q == CNT_MAX);
    assign frame_viol = keep_viol | overlen;

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            frame_bad_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            data_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_bad_q <= frame_bad_d;
            lfsr_q      <= lfsr_d;
            data_err_q  <= data_err_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        frame_bad_d = frame_bad_q;
        if (!CHANNEL_UP) begin
            state_d     = IDLE;
            beat_cnt_d  = '0;
            frame_bad_d = 1'b0;
        end else if (rx_vld) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_last) begin
                        state_d     = IN_FRAME;
                        beat_cnt_d  = CNT_W'(1);
                        frame_bad_d = keep_viol;
                    end
                end
                IN_FRAME: begin
                    // The beat arriving with the counter at the limit is beat MAX+1.
                    if (overlen) begin
                        state_d     = rx_last ? IDLE : DISCARD;
                        beat_cnt_d  = rx_last ? '0 : beat_cnt_q;
                        frame_bad_d = ~rx_last;
                    end else if (rx_last) begin
                        state_d     = IDLE;
                        beat_cnt_d  = '0;
                        frame_bad_d = 1'b0;
                    end else begin
                        beat_cnt_d  = beat_cnt_q + 1'b1;
                        frame_bad_d = frame_bad_q | keep_viol;
                    end
                end
                DISCARD: begin
                    if (rx_last) begin
                        state_d     = IDLE;
                        beat_cnt_d  = '0;
                        frame_bad_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    beat_cnt_d  = '0;
                    frame_bad_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        data_err_d  = rx_vld & byte_mis;
        frame_err_d = rx_vld & frame_viol;
        close_ok    = rx_vld & rx_last & (state_q != DISCARD) & ~frame_viol & ~frame_bad_q;
        frame_cnt_d = CHANNEL_UP ? (frame_cnt_q + 16'(close_ok)) : '0;
        if (!CHANNEL_UP) begin
            lfsr_d = LFSR_SEED;
        end else if (rx_vld) begin
            lfsr_d = lfsr16_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    sat_counter #(.WIDTH(8), .MAX(ERR_CNT_MAX)) u_data_err_cnt (
        .clk   (USER_CLK),
        .rst_n (RESET_N),
        .inc   (data_err_d),
        .clr   (~CHANNEL_UP),
        .value (ERR_COUNT)
    );

    sat_counter #(.WIDTH(8), .MAX(ERR_CNT_MAX)) u_frame_err_cnt (
        .clk   (USER_CLK),
        .rst_n (RESET_N),
        .inc   (frame_err_d),
        .clr   (~CHANNEL_UP),
        .value (FRAME_ERR_COUNT)
    );

    assign DATA_ERR    = data_err_q;
    assign FRAME_ERR   = frame_err_q;
    assign FRAME_COUNT = frame_cnt_q;

endmodule

// File: tb/tb_aurora_rx_frame_checker.sv
// Directed bench for aurora_rx_frame_checker with an 8-beat frame limit.
module tb_aurora_rx_frame_checker;

    logic        USER_CLK = 1'b0;
    logic        RESET_N;
    logic        CHANNEL_UP;
    logic        DATA_ERR;
    logic        FRAME_ERR;
    logic [7:0]  ERR_COUNT;
    logic [7:0]  FRAME_ERR_COUNT;
    logic [15:0] FRAME_COUNT;

    int          checks   = 0;
    int          failures = 0;
    int          de_seen  = 0;
    int          fe_seen  = 0;
    logic [15:0] tx_lfsr;

    always #5 USER_CLK = ~USER_CLK;

    aurora_rx_frame_checker_if #(.DATA_WIDTH(16), .STRB_WIDTH(2)) rx_if ();

    aurora_rx_frame_checker #(
        .DATA_WIDTH      (16),
        .STRB_WIDTH      (2),
        .MAX_FRAME_BEATS (8),
        .LFSR_SEED       (16'hABCD)
    ) dut (
        .USER_CLK        (USER_CLK),
        .RESET_N         (RESET_N),
        .CHANNEL_UP      (CHANNEL_UP),
        .rx              (rx_if),
        .DATA_ERR        (DATA_ERR),
        .FRAME_ERR       (FRAME_ERR),
        .ERR_COUNT       (ERR_COUNT),
        .FRAME_ERR_COUNT (FRAME_ERR_COUNT),
        .FRAME_COUNT     (FRAME_COUNT)
    );

    function automatic logic [15:0] step(input logic [15:0] c);
        logic fb;
        fb = ~(c[15] ^ c[13] ^ c[12] ^ c[10]);
        return {c[14:0], fb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic l);
        @(negedge USER_CLK);
        rx_if.RX_TDATA  = d;
        rx_if.RX_TKEEP  = k;
        rx_if.RX_TLAST  = l;
        rx_if.RX_TVALID = 1'b1;
        @(posedge USER_CLK);
        #1;
        de_seen += int'(DATA_ERR);
        fe_seen += int'(FRAME_ERR);
    endtask

    task automatic beat(input logic [15:0] mask, input logic [1:0] k, input logic l);
        drive(tx_lfsr ^ mask, k, l);
        tx_lfsr = step(tx_lfsr);
    endtask

    task automatic idle();
        @(negedge USER_CLK);
        rx_if.RX_TVALID = 1'b0;
        rx_if.RX_TLAST  = 1'b0;
        @(posedge USER_CLK);
        #1;
    endtask

    task automatic frame(input int n, input logic [15:0] mask);
        for (int i = 0; i < n; i++) beat(mask, 2'b11, (i == n - 1));
        idle();
    endtask

    task automatic check_cnts(input string tag, input int fc, input int ec, input int fec);
        check({tag, "_frame_count"}, FRAME_COUNT, fc);
        check({tag, "_err_count"}, ERR_COUNT, ec);
        check({tag, "_frame_err_count"}, FRAME_ERR_COUNT, fec);
    endtask

    initial begin
        RESET_N         = 1'b0;
        CHANNEL_UP      = 1'b0;
        rx_if.RX_TDATA  = '0;
        rx_if.RX_TKEEP  = '0;
        rx_if.RX_TLAST  = 1'b0;
        rx_if.RX_TVALID = 1'b0;
        tx_lfsr         = 16'hABCD;
        #1;
        check("rst_data_err", DATA_ERR, 0);
        check("rst_frame_err", FRAME_ERR, 0);
        check_cnts("rst", 0, 0, 0);

        @(negedge USER_CLK);
        RESET_N    = 1'b1;
        CHANNEL_UP = 1'b1;

        // Three clean 4-beat frames
        for (int f = 0; f < 3; f++) frame(4, 16'h0000);
        check_cnts("clean", 3, 0, 0);
        check("clean_de_pulses", de_seen, 0);
        check("clean_fe_pulses", fe_seen, 0);

        // Bit 0 of beat 2 flipped
        de_seen = 0;
        beat(16'h0000, 2'b11, 1'b0);
        check("corrupt_b1_de", DATA_ERR, 0);
        beat(16'h0001, 2'b11, 1'b0);
        check("corrupt_b2_de", DATA_ERR, 1);
        beat(16'h0000, 2'b11, 1'b0);
        check("corrupt_b3_de", DATA_ERR, 0);
        beat(16'h0000, 2'b11, 1'b1);
        idle();
        check("corrupt_de_pulses", de_seen, 1);
        check_cnts("corrupt", 4, 1, 0);

        // Partial last beat, garbage in the unkept low byte
        beat(16'h0000, 2'b11, 1'b0);
        beat(16'h005A, 2'b10, 1'b1);
        check("partial_de", DATA_ERR, 0);
        check("partial_fe", FRAME_ERR, 0);
        idle();
        check_cnts("partial", 5, 1, 0);

        // Empty last beat
        beat(16'h0000, 2'b11, 1'b0);
        beat(16'hFFFF, 2'b00, 1'b1);
        check("keep00_fe", FRAME_ERR, 1);
        check("keep00_de", DATA_ERR, 0);
        idle();
        check("idle_fe_low", FRAME_ERR, 0);
        check_cnts("keep00", 5, 1, 1);

        // 9-beat frame: error on beat 9 only
        fe_seen = 0;
        for (int i = 0; i < 8; i++) beat(16'h0000, 2'b11, 1'b0);
        check("len8_no_fe", fe_seen, 0);
        beat(16'h0000, 2'b11, 1'b1);
        check("len9_fe", FRAME_ERR, 1);
        idle();
        check_cnts("len9", 5, 1, 2);

        // 11-beat frame: one error, then discard to TLAST
        fe_seen = 0;
        for (int i = 0; i < 11; i++) beat(16'h0000, 2'b11, (i == 10));
        idle();
        check("len11_fe_pulses", fe_seen, 1);
        check_cnts("len11", 5, 1, 3);

        // Exactly MAX_FRAME_BEATS is legal
        fe_seen = 0;
        frame(8, 16'h0000);
        check("len8_fe_pulses", fe_seen, 0);
        check_cnts("len8", 6, 1, 3);

        // Non-last beat with partial keep marks the frame bad
        fe_seen = 0;
        beat(16'h00FF, 2'b10, 1'b0);
        check("midkeep_fe", FRAME_ERR, 1);
        check("midkeep_de", DATA_ERR, 0);
        beat(16'h0000, 2'b11, 1'b0);
        beat(16'h0000, 2'b11, 1'b1);
        idle();
        check("midkeep_fe_pulses", fe_seen, 1);
        check_cnts("midkeep", 6, 1, 4);

        // Data and framing errors on the same beat
        beat(16'h8000, 2'b10, 1'b0);
        check("both_de", DATA_ERR, 1);
        check("both_fe", FRAME_ERR, 1);
        beat(16'h0000, 2'b11, 1'b1);
        idle();
        check_cnts("both", 6, 2, 5);

        // 300 corrupted beats saturate the data error counter
        for (int f = 0; f < 75; f++) frame(4, 16'h0001);
        check_cnts("sat", 81, 255, 5);
        beat(16'h0001, 2'b11, 1'b1);
        check("sat_de_pulse", DATA_ERR, 1);
        idle();
        check_cnts("sat_hold", 82, 255, 5);

        // Link drop mid-frame; beats while down are ignored
        beat(16'h0000, 2'b11, 1'b0);
        beat(16'h0000, 2'b11, 1'b0);
        @(negedge USER_CLK);
        CHANNEL_UP      = 1'b0;
        rx_if.RX_TDATA  = 16'h1234;
        rx_if.RX_TKEEP  = 2'b01;
        rx_if.RX_TLAST  = 1'b1;
        rx_if.RX_TVALID = 1'b1;
        repeat (3) @(posedge USER_CLK);
        #1;
        check("down_de", DATA_ERR, 0);
        check("down_fe", FRAME_ERR, 0);
        check_cnts("down", 0, 0, 0);
        @(negedge USER_CLK);
        CHANNEL_UP      = 1'b1;
        rx_if.RX_TVALID = 1'b0;
        rx_if.RX_TLAST  = 1'b0;
        tx_lfsr         = 16'hABCD;
        de_seen         = 0;
        fe_seen         = 0;
        frame(4, 16'h0000);
        check_cnts("relink", 1, 0, 0);
        check("relink_de_pulses", de_seen, 0);
        check("relink_fe_pulses", fe_seen, 0);

        // Async reset in the middle of a beat
        beat(16'h0000, 2'b11, 1'b0);
        beat(16'h0100, 2'b11, 1'b0);
        check("prereset_de", DATA_ERR, 1);
        check("prereset_err_count", ERR_COUNT, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("areset_de", DATA_ERR, 0);
        check("areset_fe", FRAME_ERR, 0);
        check_cnts("areset", 0, 0, 0);
        @(negedge USER_CLK);
        rx_if.RX_TVALID = 1'b0;
        rx_if.RX_TLAST  = 1'b0;
        RESET_N         = 1'b1;
        tx_lfsr         = 16'hABCD;
        de_seen         = 0;
        frame(4, 16'h0000);
        check_cnts("postreset", 1, 0, 0);
        check("postreset_de_pulses", de_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
